hash_op_sequencer: RTL and testbench

- Host-side front end for the hash table controller.
- Accepts one request at a time (read / write / delete) over a valid/ready handshake.
- Presents the key for LOOKUP_LATENCY cycles so the hash units and bucket memories settle, then drives the operation code for exactly one cycle.
- Captures the controller's result flags and read data into a one-entry response register, returned to the host over a second valid/ready handshake.

---
 rtl/hash_op_sequencer_if.sv | 26 ++
 rtl/hash_op_sequencer.sv | 139 +++++++++++++
 tb/tb_hash_op_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hash_op_sequencer_if.sv
// Host-side request/response handshake bundle for hash_op_sequencer.
// slave = sequencer side, master = host side.
interface hash_op_sequencer_if #(
    parameter int KEY_WIDTH  = 2,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [1:0]            req_op_i;
    logic [KEY_WIDTH-1:0]  req_key_i;
    logic [DATA_WIDTH-1:0] req_data_i;
    logic                  resp_valid_o;
    logic                  resp_ready_i;
    logic [2:0]            resp_status_o;
    logic [DATA_WIDTH-1:0] resp_data_o;

    modport slave (
        input  req_valid_i, req_op_i, req_key_i, req_data_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_status_o, resp_data_o
    );

    modport master (
        output req_valid_i, req_op_i, req_key_i, req_data_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_status_o, resp_data_o
    );
endinterface

// File: rtl/hash_op_sequencer.sv
// Host front end for the hash table controller: one request in flight, key settle, one-cycle op, held response.
// Optional saturating ok/error counters are built when HASH_SEQ_STATS_EN is defined.
module hash_op_sequencer #(
    parameter int KEY_WIDTH      = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int LOOKUP_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    hash_op_sequencer_if.slave    host,
    output logic [KEY_WIDTH-1:0]  key_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [1:0]            op_o,
    input  logic [DATA_WIDTH-1:0] ctrl_read_data_i,
    input  logic                  ctrl_valid_i,
    input  logic                  ctrl_no_deletion_target_i,
    input  logic                  ctrl_no_write_space_i,
    input  logic                  ctrl_no_element_found_i,
    input  logic                  ctrl_key_already_present_i,
    output logic [15:0]           stat_ok_cnt_o,
    output logic [15:0]           stat_err_cnt_o
);

    typedef enum logic [1:0] {IDLE, LOOKUP, EXECUTE, RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q;
    logic [1:0]            op_q;
    logic [KEY_WIDTH-1:0]  key_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [2:0]            status_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  accept;
    logic [2:0]            status_d;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [3:0]            unused_ctrl_flags;

    function automatic logic [2:0] result_code(input logic vld, input logic no_del,
                                               input logic no_space, input logic present,
                                               input logic not_found);
        if (!vld)           return 3'b111;
        else if (no_del)    return 3'b100;
        else if (no_space)  return 3'b010;
        else if (present)   return 3'b011;
        else if (not_found) return 3'b001;
        else                return 3'b000;
    endfunction

    // The controller's flag nibble is reported through the status code instead.
    assign unused_ctrl_flags = ctrl_read_data_i[DATA_WIDTH-1 -: 4];

    assign accept   = (state_q == IDLE) && host.req_valid_i && (host.req_op_i != 2'b00);
    assign status_d = result_code(ctrl_valid_i, ctrl_no_deletion_target_i, ctrl_no_write_space_i,
                                  ctrl_key_already_present_i, ctrl_no_element_found_i);
    assign rdata_d  = (op_q == 2'b01 && status_d == 3'b000)
                      ? {4'b0000, ctrl_read_data_i[DATA_WIDTH-5:0]} : '0;

    always_comb begin
        state_d           = state_q;
        host.req_ready_o  = 1'b0;
        host.resp_valid_o = 1'b0;
        op_o              = 2'b00;
        case (state_q)
            IDLE: begin
                host.req_ready_o = 1'b1;
                if (accept) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (cnt_q <= 4'd1) state_d = EXECUTE;
            end
            EXECUTE: begin
                op_o    = op_q;
                state_d = RESP;
            end
            RESP: begin
                host.resp_valid_o = 1'b1;
                if (host.resp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= 2'b00;
            key_q    <= '0;
            data_q   <= '0;
            status_q <= 3'b000;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= host.req_op_i;
                key_q  <= host.req_key_i;
                data_q <= host.req_data_i;
                cnt_q  <= 4'(LOOKUP_LATENCY);
            end else if (state_q == LOOKUP) begin
                cnt_q <= cnt_q - 4'd1;
            end
            // EXECUTE edge: the response register is loaded exactly once per request
            if (state_q == EXECUTE) begin
                status_q <= status_d;
                rdata_q  <= rdata_d;
            end
        end
    end

    assign key_o              = key_q;
    assign data_o             = data_q;
    assign host.resp_status_o = status_q;
    assign host.resp_data_o   = rdata_q;

`ifdef HASH_SEQ_STATS_EN
    logic [15:0] ok_cnt_q, err_cnt_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ok_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else if (state_q == EXECUTE) begin
            if (status_d == 3'b000) ok_cnt_q  <= sat_inc(ok_cnt_q);
            else                    err_cnt_q <= sat_inc(err_cnt_q);
        end
    end

    assign stat_ok_cnt_o  = ok_cnt_q;
    assign stat_err_cnt_o = err_cnt_q;
`else
    assign stat_ok_cnt_o  = '0;
    assign stat_err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hash_op_sequencer.sv
// Randomized self-checking bench for hash_op_sequencer against a behavioural reference model.
module tb_hash_op_sequencer;
    localparam int KW  = 2;
    localparam int DW  = 32;
    localparam int LAT = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [KW-1:0] key_o;
    logic [DW-1:0] data_o;
    logic [1:0]    op_o;
    logic [DW-1:0] ctrl_read_data;
    logic          ctrl_valid, f_ndt, f_nws, f_nef, f_kap;
    logic [15:0]   stat_ok, stat_err;

    hash_op_sequencer_if #(.KEY_WIDTH(KW), .DATA_WIDTH(DW)) host_if ();

    hash_op_sequencer #(.KEY_WIDTH(KW), .DATA_WIDTH(DW), .LOOKUP_LATENCY(LAT)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .host                       (host_if.slave),
        .key_o                      (key_o),
        .data_o                     (data_o),
        .op_o                       (op_o),
        .ctrl_read_data_i           (ctrl_read_data),
        .ctrl_valid_i               (ctrl_valid),
        .ctrl_no_deletion_target_i  (f_ndt),
        .ctrl_no_write_space_i      (f_nws),
        .ctrl_no_element_found_i    (f_nef),
        .ctrl_key_already_present_i (f_kap),
        .stat_ok_cnt_o              (stat_ok),
        .stat_err_cnt_o             (stat_err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int exp_ok  = 0;
    int exp_err = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observations of the most recent transaction
    int            obs_exec_cyc, obs_exec_abs, obs_op_cnt, obs_rsp_cyc;
    logic [1:0]    obs_op;
    logic [KW-1:0] obs_key, obs_key_after;
    logic [DW-1:0] obs_data, obs_rdata;
    logic [2:0]    obs_status;
    logic          obs_ready_start, obs_valid_after, obs_ready_after;
    bit            obs_unstable, obs_ready_hold, obs_op_hold;
    logic [15:0]   obs_ok, obs_err;

    function automatic logic [2:0] model_status(input logic cv, input logic ndt, input logic nws,
                                                input logic nef, input logic kap);
        bit         hit[5];
        logic [2:0] code[5];
        logic [2:0] res;
        bit         found;
        hit   = '{!cv, ndt, nws, kap, nef};
        code  = '{3'b111, 3'b100, 3'b010, 3'b011, 3'b001};
        res   = 3'b000;
        found = 0;
        for (int i = 0; i < 5; i++)
            if (!found && hit[i]) begin res = code[i]; found = 1; end
        return res;
    endfunction

    function automatic logic [DW-1:0] model_data(input logic [1:0] op, input logic [2:0] st,
                                                 input logic [DW-1:0] rd);
        longint unsigned m;
        m = 64'd1 << (DW - 4);
        if (op == 2'b01 && st == 3'b000) return DW'(64'(rd) % m);
        return '0;
    endfunction

    function automatic logic [15:0] stat_want(input int c);
`ifdef HASH_SEQ_STATS_EN
        return (c > 65535) ? 16'hFFFF : 16'(c);
`else
        return (c >= 0) ? 16'h0000 : 16'h0000;
`endif
    endfunction

    task automatic model_count(input logic [2:0] st);
        if (st == 3'b000) exp_ok++;
        else              exp_err++;
    endtask

    // Drives one request from a negedge and records what the DUT does; no judgement here.
    task automatic run_txn(input logic [1:0] op, input logic [KW-1:0] key, input logic [DW-1:0] data,
                           input logic [DW-1:0] rd, input logic cv, input logic ndt, input logic nws,
                           input logic nef, input logic kap, input int hold, input bit hold_req);
        host_if.req_op_i     = op;
        host_if.req_key_i    = key;
        host_if.req_data_i   = data;
        host_if.req_valid_i  = 1'b1;
        host_if.resp_ready_i = 1'b0;
        ctrl_read_data = rd; ctrl_valid = cv; f_ndt = ndt; f_nws = nws; f_nef = nef; f_kap = kap;
        obs_ready_start = host_if.req_ready_o;
        obs_exec_cyc = -1; obs_exec_abs = -1; obs_op_cnt = 0; obs_rsp_cyc = -1;
        obs_op = 2'b00; obs_key = '0; obs_data = '0; obs_status = 3'b000; obs_rdata = '0;
        obs_unstable = 0; obs_ready_hold = 0; obs_op_hold = 0;
        @(posedge clk); @(negedge clk);
        if (!hold_req) host_if.req_valid_i = 1'b0;
        for (int n = 1; n <= 40 && obs_rsp_cyc < 0; n++) begin
            if (op_o !== 2'b00) begin
                obs_op_cnt++; obs_exec_cyc = n; obs_exec_abs = cyc;
                obs_op = op_o; obs_key = key_o; obs_data = data_o;
            end
            if (host_if.resp_valid_o === 1'b1) begin
                obs_rsp_cyc = n; obs_status = host_if.resp_status_o; obs_rdata = host_if.resp_data_o;
            end else begin
                @(posedge clk); @(negedge clk);
            end
        end
        if (obs_rsp_cyc >= 0) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); @(negedge clk);
                if (host_if.resp_valid_o !== 1'b1 || host_if.resp_status_o !== obs_status ||
                    host_if.resp_data_o !== obs_rdata) obs_unstable = 1;
                if (host_if.req_ready_o !== 1'b0) obs_ready_hold = 1;
                if (op_o !== 2'b00) obs_op_hold = 1;
            end
            host_if.resp_ready_i = 1'b1;
            @(posedge clk); @(negedge clk);
            host_if.resp_ready_i = 1'b0;
        end
        obs_valid_after = host_if.resp_valid_o;
        obs_ready_after = host_if.req_ready_o;
        obs_key_after   = key_o;
        obs_ok  = stat_ok;
        obs_err = stat_err;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        host_if.req_valid_i = 1'b0; host_if.req_op_i = 2'b00; host_if.req_key_i = '0;
        host_if.req_data_i = '0; host_if.resp_ready_i = 1'b0;
        ctrl_read_data = '0; ctrl_valid = 1'b1; f_ndt = 0; f_nws = 0; f_nef = 0; f_kap = 0;
        repeat (3) @(negedge clk);
        n_tests++; if (host_if.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", host_if.req_ready_o); end
        n_tests++; if (host_if.resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", host_if.resp_valid_o); end
        n_tests++; if (op_o !== 2'b00) begin n_fail++; $display("FAIL rst_op: got %b want 00", op_o); end
        n_tests++; if (key_o !== '0 || data_o !== '0) begin n_fail++; $display("FAIL rst_key_data: got %h/%h want 0/0", key_o, data_o); end
        n_tests++; if (host_if.resp_status_o !== 3'b000 || host_if.resp_data_o !== '0) begin n_fail++; $display("FAIL rst_resp: got %b/%h want 000/0", host_if.resp_status_o, host_if.resp_data_o); end
        n_tests++; if (stat_ok !== 16'h0 || stat_err !== 16'h0) begin n_fail++; $display("FAIL rst_stats: got %0d/%0d want 0/0", stat_ok, stat_err); end
        reset = 1'b1;
        @(negedge clk);
        n_tests++; if (host_if.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", host_if.req_ready_o); end
    endtask

    task automatic test_write_basic();
        logic [DW-1:0] rd;
        rd = $urandom;
        run_txn(2'b10, 2'b01, 32'h0000_00AA, rd, 1'b1, 0, 0, 0, 0, 0, 0);
        model_count(3'b000);
        n_tests++; if (obs_ready_start !== 1'b1) begin n_fail++; $display("FAIL wr_ready: got %b want 1", obs_ready_start); end
        n_tests++; if (obs_exec_cyc !== LAT + 1) begin n_fail++; $display("FAIL wr_exec_cycle: got %0d want %0d", obs_exec_cyc, LAT + 1); end
        n_tests++; if (obs_op_cnt !== 1) begin n_fail++; $display("FAIL wr_op_cycles: got %0d want 1", obs_op_cnt); end
        n_tests++; if (obs_op !== 2'b10) begin n_fail++; $display("FAIL wr_op: got %b want 10", obs_op); end
        n_tests++; if (obs_key !== 2'b01 || obs_data !== 32'h0000_00AA) begin n_fail++; $display("FAIL wr_key_data: got %b/%h want 01/000000aa", obs_key, obs_data); end
        n_tests++; if (obs_rsp_cyc !== LAT + 2) begin n_fail++; $display("FAIL wr_resp_cycle: got %0d want %0d", obs_rsp_cyc, LAT + 2); end
        n_tests++; if (obs_status !== 3'b000 || obs_rdata !== '0) begin n_fail++; $display("FAIL wr_resp: got %b/%h want 000/0", obs_status, obs_rdata); end
        n_tests++; if (obs_valid_after !== 1'b0 || obs_ready_after !== 1'b1) begin n_fail++; $display("FAIL wr_after: got valid %b ready %b want 0 1", obs_valid_after, obs_ready_after); end
        n_tests++; if (obs_key_after !== 2'b01) begin n_fail++; $display("FAIL wr_key_hold: got %b want 01", obs_key_after); end
        n_tests++; if (obs_ok !== stat_want(exp_ok)) begin n_fail++; $display("FAIL wr_stat_ok: got %0d want %0d", obs_ok, stat_want(exp_ok)); end
    endtask

    task automatic test_read_basic();
        run_txn(2'b01, 2'b01, $urandom, 32'hF000_00AA, 1'b1, 0, 0, 0, 0, 0, 0);
        model_count(3'b000);
        n_tests++; if (obs_op !== 2'b01 || obs_exec_cyc !== LAT + 1) begin n_fail++; $display("FAIL rd_op: got %b@%0d want 01@%0d", obs_op, obs_exec_cyc, LAT + 1); end
        n_tests++; if (obs_status !== 3'b000) begin n_fail++; $display("FAIL rd_status: got %b want 000", obs_status); end
        n_tests++; if (obs_rdata !== 32'h0000_00AA) begin n_fail++; $display("FAIL rd_data: got %h want 000000aa", obs_rdata); end
        n_tests++; if (obs_ok !== stat_want(exp_ok)) begin n_fail++; $display("FAIL rd_stat_ok: got %0d want %0d", obs_ok, stat_want(exp_ok)); end
    endtask

    task automatic test_read_not_found();
        run_txn(2'b01, 2'b11, '0, 32'h0123_4567, 1'b1, 0, 0, 1, 0, 0, 0);
        model_count(3'b001);
        n_tests++; if (obs_status !== 3'b001 || obs_rdata !== '0) begin n_fail++; $display("FAIL nf_resp: got %b/%h want 001/0", obs_status, obs_rdata); end
        n_tests++; if (obs_err !== stat_want(exp_err)) begin n_fail++; $display("FAIL nf_stat_err: got %0d want %0d", obs_err, stat_want(exp_err)); end
        n_tests++; if (obs_ok !== stat_want(exp_ok)) begin n_fail++; $display("FAIL nf_stat_ok: got %0d want %0d", obs_ok, stat_want(exp_ok)); end
    endtask

    task automatic test_backpressure();
        logic [KW-1:0] k;
        logic [DW-1:0] d;
        k = KW'($urandom); d = $urandom;
        run_txn(2'b10, k, d, '0, 1'b1, 0, 0, 0, 1, 5, 1);
        model_count(3'b011);
        n_tests++; if (obs_status !== 3'b011) begin n_fail++; $display("FAIL bp_status: got %b want 011", obs_status); end
        n_tests++; if (obs_unstable) begin n_fail++; $display("FAIL bp_stable: got unstable want stable"); end
        n_tests++; if (obs_ready_hold) begin n_fail++; $display("FAIL bp_ready: got 1 during RESP want 0"); end
        n_tests++; if (obs_op_hold) begin n_fail++; $display("FAIL bp_op: got nonzero during RESP want 00"); end
        n_tests++; if (obs_ready_after !== 1'b1) begin n_fail++; $display("FAIL bp_idle: got ready %b want 1", obs_ready_after); end
        // the held request is taken on the first IDLE edge
        run_txn(2'b10, k, d, '0, 1'b1, 0, 0, 0, 1, 0, 0);
        model_count(3'b011);
        n_tests++; if (obs_exec_cyc !== LAT + 1 || obs_op_cnt !== 1) begin n_fail++; $display("FAIL bp_next_accept: got exec %0d cnt %0d want %0d 1", obs_exec_cyc, obs_op_cnt, LAT + 1); end
        n_tests++; if (obs_key !== k || obs_data !== d) begin n_fail++; $display("FAIL bp_next_key: got %h/%h want %h/%h", obs_key, obs_data, k, d); end
        n_tests++; if (obs_err !== stat_want(exp_err)) begin n_fail++; $display("FAIL bp_stat_err: got %0d want %0d", obs_err, stat_want(exp_err)); end
    endtask

    task automatic test_protocol_error();
        logic [1:0] op;
        op = 2'($urandom_range(1, 3));
        run_txn(op, KW'($urandom), $urandom, $urandom, 1'b0, 1, 1, 1, 1, 0, 0);
        model_count(3'b111);
        n_tests++; if (obs_status !== 3'b111 || obs_rdata !== '0) begin n_fail++; $display("FAIL perr_resp: got %b/%h want 111/0", obs_status, obs_rdata); end
        n_tests++; if (obs_err !== stat_want(exp_err)) begin n_fail++; $display("FAIL perr_stat_err: got %0d want %0d", obs_err, stat_want(exp_err)); end
    endtask

    task automatic test_nop();
        bit saw_op, saw_resp, lost_ready;
        saw_op = 0; saw_resp = 0; lost_ready = 0;
        host_if.req_op_i = 2'b00; host_if.req_valid_i = 1'b1; host_if.req_key_i = KW'($urandom);
        n_tests++; if (host_if.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL nop_ready: got %b want 1", host_if.req_ready_o); end
        @(posedge clk); @(negedge clk);
        host_if.req_valid_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (op_o !== 2'b00) saw_op = 1;
            if (host_if.resp_valid_o !== 1'b0) saw_resp = 1;
            if (host_if.req_ready_o !== 1'b1) lost_ready = 1;
            @(posedge clk); @(negedge clk);
        end
        n_tests++; if (saw_op) begin n_fail++; $display("FAIL nop_op: got nonzero op want 00"); end
        n_tests++; if (saw_resp) begin n_fail++; $display("FAIL nop_resp: got resp_valid 1 want 0"); end
        n_tests++; if (lost_ready) begin n_fail++; $display("FAIL nop_idle: got ready 0 want 1"); end
        n_tests++; if (stat_ok !== stat_want(exp_ok) || stat_err !== stat_want(exp_err)) begin n_fail++; $display("FAIL nop_stats: got %0d/%0d want %0d/%0d", stat_ok, stat_err, stat_want(exp_ok), stat_want(exp_err)); end
    endtask

    task automatic test_back_to_back();
        int prev;
        logic [2:0] st;
        prev = -1;
        for (int i = 0; i < 6; i++) begin
            run_txn(2'($urandom_range(1, 3)), KW'($urandom), $urandom, $urandom, 1'b1, 0, 0, 0, 0, 0, 0);
            st = model_status(1'b1, 0, 0, 0, 0);
            model_count(st);
            n_tests++; if (obs_status !== st) begin n_fail++; $display("FAIL b2b_status[%0d]: got %b want %b", i, obs_status, st); end
            if (prev >= 0) begin
                n_tests++; if (obs_exec_abs - prev !== LAT + 3) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, obs_exec_abs - prev, LAT + 3); end
            end
            prev = obs_exec_abs;
        end
    endtask

    task automatic test_random();
        logic [1:0]    op;
        logic [KW-1:0] k;
        logic [DW-1:0] d, rd;
        logic          cv, ndt, nws, nef, kap;
        logic [2:0]    st;
        logic [DW-1:0] ed;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(1, 3)); k = KW'($urandom); d = $urandom; rd = $urandom;
            cv  = ($urandom_range(0, 7) != 0);
            ndt = ($urandom_range(0, 3) == 0); nws = ($urandom_range(0, 3) == 0);
            nef = ($urandom_range(0, 3) == 0); kap = ($urandom_range(0, 3) == 0);
            run_txn(op, k, d, rd, cv, ndt, nws, nef, kap, int'($urandom_range(0, 3)), 0);
            st = model_status(cv, ndt, nws, nef, kap);
            ed = model_data(op, st, rd);
            model_count(st);
            n_tests++; if (obs_exec_cyc !== LAT + 1 || obs_op !== op || obs_op_cnt !== 1) begin n_fail++; $display("FAIL rnd_op[%0d]: got %b@%0d x%0d want %b@%0d x1", i, obs_op, obs_exec_cyc, obs_op_cnt, op, LAT + 1); end
            n_tests++; if (obs_key !== k || obs_data !== d) begin n_fail++; $display("FAIL rnd_key_data[%0d]: got %h/%h want %h/%h", i, obs_key, obs_data, k, d); end
            n_tests++; if (obs_status !== st || obs_rdata !== ed) begin n_fail++; $display("FAIL rnd_resp[%0d]: got %b/%h want %b/%h", i, obs_status, obs_rdata, st, ed); end
            n_tests++; if (obs_unstable) begin n_fail++; $display("FAIL rnd_stable[%0d]: got unstable want stable", i); end
            n_tests++; if (obs_ok !== stat_want(exp_ok) || obs_err !== stat_want(exp_err)) begin n_fail++; $display("FAIL rnd_stats[%0d]: got %0d/%0d want %0d/%0d", i, obs_ok, obs_err, stat_want(exp_ok), stat_want(exp_err)); end
        end
    endtask

    task automatic test_reset_mid();
        bit saw_op, saw_resp;
        saw_op = 0; saw_resp = 0;
        host_if.req_op_i = 2'b10; host_if.req_key_i = 2'b10; host_if.req_data_i = 32'h1234_5678;
        host_if.req_valid_i = 1'b1; host_if.resp_ready_i = 1'b0; ctrl_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        host_if.req_valid_i = 1'b0;
        reset = 1'b0;
        #1;
        exp_ok = 0; exp_err = 0;
        n_tests++; if (op_o !== 2'b00 || host_if.resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out: got op %b valid %b want 00 0", op_o, host_if.resp_valid_o); end
        n_tests++; if (host_if.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_rst_idle: got ready %b want 1", host_if.req_ready_o); end
        n_tests++; if (stat_ok !== 16'h0 || stat_err !== 16'h0 || key_o !== '0) begin n_fail++; $display("FAIL mid_rst_clear: got %0d/%0d key %b want 0/0 key 0", stat_ok, stat_err, key_o); end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); @(negedge clk);
            if (op_o !== 2'b00) saw_op = 1;
            if (host_if.resp_valid_o !== 1'b0) saw_resp = 1;
        end
        n_tests++; if (saw_op || saw_resp) begin n_fail++; $display("FAIL mid_rst_no_op: got op %b resp %b want 0 0", saw_op, saw_resp); end
        run_txn(2'b11, 2'b00, '0, '0, 1'b1, 0, 0, 0, 0, 0, 0);
        model_count(3'b000);
        n_tests++; if (obs_op !== 2'b11 || obs_exec_cyc !== LAT + 1) begin n_fail++; $display("FAIL mid_rst_new_op: got %b@%0d want 11@%0d", obs_op, obs_exec_cyc, LAT + 1); end
        n_tests++; if (obs_ok !== stat_want(exp_ok) || obs_err !== stat_want(exp_err)) begin n_fail++; $display("FAIL mid_rst_stats: got %0d/%0d want %0d/%0d", obs_ok, obs_err, stat_want(exp_ok), stat_want(exp_err)); end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_read_not_found();
        test_backpressure();
        test_protocol_error();
        test_nop();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
